// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the D-stage hazard scoreboard: forwarding source codes
// and the Tnew/Tuse values used by the decoder.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10,
        FWD_W  = 2'b11
    } fwd_sel_e;

    localparam logic [1:0] T_LOAD = 2'd2;
    localparam logic [1:0] T_CAL  = 2'd1;
    localparam logic [1:0] T_LINK = 2'd0;

endpackage

// File: rtl/hazard_scoreboard_src_check.sv
// Per-source hazard check: picks the youngest in-flight writer of one D-stage
// source and turns its Tnew/Tuse relation into a stall request and a forward select.
module hazard_src_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = 2
) (
    input  logic             e_valid,
    input  logic [REG_W-1:0] e_wreg,
    input  logic [T_W-1:0]   e_tnew,
    input  logic             m_valid,
    input  logic [REG_W-1:0] m_wreg,
    input  logic [T_W-1:0]   m_tnew,
    input  logic             w_valid,
    input  logic [REG_W-1:0] w_wreg,
    input  logic [T_W-1:0]   w_tnew,
    input  logic [REG_W-1:0] src,
    input  logic             src_re,
    input  logic [T_W-1:0]   tuse,
    output logic             stall_req,
    output logic [1:0]       fwd_sel
);

    logic           hit;
    logic [T_W-1:0] win_tnew;
    fwd_sel_e       win_code;

    // Youngest stage wins; register $0 is hardwired and never a hazard.
    always_comb begin
        hit      = 1'b0;
        win_tnew = '0;
        win_code = FWD_RF;
        if (src_re && (src != '0)) begin
            if (e_valid && (e_wreg == src)) begin
                hit      = 1'b1;
                win_tnew = e_tnew;
                win_code = FWD_E;
            end else if (m_valid && (m_wreg == src)) begin
                hit      = 1'b1;
                win_tnew = m_tnew;
                win_code = FWD_M;
            end else if (w_valid && (w_wreg == src)) begin
                hit      = 1'b1;
                win_tnew = w_tnew;
                win_code = FWD_W;
            end
        end
        stall_req = hit && (win_tnew > tuse);
        fwd_sel   = (hit && (win_tnew == '0)) ? win_code : FWD_RF;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard tracking in-flight writers through E/M/W.
// Optional stall-cycle counter (stall_cnt, cnt_clr) enabled by HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_re,
    input  logic             id_rt_re,
    input  logic [T_W-1:0]   id_tuse_rs,
    input  logic [T_W-1:0]   id_tuse_rt,
    input  logic             id_we,
    input  logic [REG_W-1:0] id_wreg,
    input  logic [T_W-1:0]   id_tnew,
    output logic             stall,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [T_W-1:0]   e_tnew,
    output logic [T_W-1:0]   m_tnew
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [31:0]      stall_cnt
`endif
);

    logic             e_valid_q, m_valid_q, w_valid_q;
    logic [REG_W-1:0] e_wreg_q, m_wreg_q, w_wreg_q;
    logic [T_W-1:0]   e_tnew_q, m_tnew_q;
    logic             rs_stall, rt_stall;
    logic             e_load;

    hazard_src_check #(.REG_W(REG_W), .T_W(T_W)) u_rs_check (
        .e_valid   (e_valid_q),
        .e_wreg    (e_wreg_q),
        .e_tnew    (e_tnew_q),
        .m_valid   (m_valid_q),
        .m_wreg    (m_wreg_q),
        .m_tnew    (m_tnew_q),
        .w_valid   (w_valid_q),
        .w_wreg    (w_wreg_q),
        .w_tnew    ('0),
        .src       (id_rs),
        .src_re    (id_rs_re),
        .tuse      (id_tuse_rs),
        .stall_req (rs_stall),
        .fwd_sel   (fwd_rs_sel)
    );

    hazard_src_check #(.REG_W(REG_W), .T_W(T_W)) u_rt_check (
        .e_valid   (e_valid_q),
        .e_wreg    (e_wreg_q),
        .e_tnew    (e_tnew_q),
        .m_valid   (m_valid_q),
        .m_wreg    (m_wreg_q),
        .m_tnew    (m_tnew_q),
        .w_valid   (w_valid_q),
        .w_wreg    (w_wreg_q),
        .w_tnew    ('0),
        .src       (id_rt),
        .src_re    (id_rt_re),
        .tuse      (id_tuse_rt),
        .stall_req (rt_stall),
        .fwd_sel   (fwd_rt_sel)
    );

    assign stall  = id_valid && (rs_stall || rt_stall);
    assign e_load = !stall && id_valid && id_we && (id_wreg != '0);
    assign e_tnew = e_tnew_q;
    assign m_tnew = m_tnew_q;

    // A stalled or non-writing D instruction leaves a cleared bubble in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_q <= 1'b0;
            e_wreg_q  <= '0;
            e_tnew_q  <= '0;
            m_valid_q <= 1'b0;
            m_wreg_q  <= '0;
            m_tnew_q  <= '0;
            w_valid_q <= 1'b0;
            w_wreg_q  <= '0;
        end else begin
            w_valid_q <= m_valid_q;
            w_wreg_q  <= m_wreg_q;
            m_valid_q <= e_valid_q;
            m_wreg_q  <= e_wreg_q;
            m_tnew_q  <= (e_tnew_q == '0) ? '0 : e_tnew_q - T_W'(1);
            e_valid_q <= e_load;
            e_wreg_q  <= e_load ? id_wreg : '0;
            e_tnew_q  <= e_load ? id_tnew : '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; also exercises the stall
// counter when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_re;
        logic       rt_re;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       we;
        logic [4:0] wreg;
        logic [1:0] tnew;
    } instr_t;

    typedef struct {
        logic       stall;
        logic [1:0] rs_sel;
        logic [1:0] rt_sel;
        logic       chk_e;
        logic [1:0] e_tnew;
        logic       chk_m;
        logic [1:0] m_tnew;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       id_rs_re, id_rt_re, id_we;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel, e_tnew, m_tnew;
`ifdef HAZARD_PERF_CNT_EN
    logic        cnt_clr;
    logic [31:0] stall_cnt;
`endif

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard #(.REG_W(5), .T_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_re   (id_rs_re),
        .id_rt_re   (id_rt_re),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_we      (id_we),
        .id_wreg    (id_wreg),
        .id_tnew    (id_tnew),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic rs_re, input logic rt_re, input logic [1:0] tu_rs,
                                  input logic [1:0] tu_rt, input logic we, input logic [4:0] wreg,
                                  input logic [1:0] tnew);
        instr_t d;
        d = '{valid: v, rs: rs, rt: rt, rs_re: rs_re, rt_re: rt_re, tuse_rs: tu_rs,
              tuse_rt: tu_rt, we: we, wreg: wreg, tnew: tnew};
        return d;
    endfunction

    function automatic exp_t ex(input logic st, input logic [1:0] rs_sel, input logic [1:0] rt_sel,
                                input logic chk_e, input logic [1:0] et,
                                input logic chk_m, input logic [1:0] mt);
        exp_t e;
        e = '{stall: st, rs_sel: rs_sel, rt_sel: rt_sel, chk_e: chk_e, e_tnew: et,
              chk_m: chk_m, m_tnew: mt};
        return e;
    endfunction

    // Drive one D-stage instruction and queue what the outputs must be for it.
    task automatic applyStimulus(input instr_t d, input exp_t e);
        id_valid   = d.valid;
        id_rs      = d.rs;
        id_rt      = d.rt;
        id_rs_re   = d.rs_re;
        id_rt_re   = d.rt_re;
        id_tuse_rs = d.tuse_rs;
        id_tuse_rt = d.tuse_rt;
        id_we      = d.we;
        id_wreg    = d.wreg;
        id_tnew    = d.tnew;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        assert (scoreboard.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard: got empty queue, want an entry", tag);
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert (stall === e.stall) else begin
                errors++;
                $error("[TB] FAIL %s stall: got %0b want %0b", tag, stall, e.stall);
            end
            checks++;
            assert (fwd_rs_sel === e.rs_sel) else begin
                errors++;
                $error("[TB] FAIL %s fwd_rs_sel: got %0b want %0b", tag, fwd_rs_sel, e.rs_sel);
            end
            checks++;
            assert (fwd_rt_sel === e.rt_sel) else begin
                errors++;
                $error("[TB] FAIL %s fwd_rt_sel: got %0b want %0b", tag, fwd_rt_sel, e.rt_sel);
            end
            if (e.chk_e) begin
                checks++;
                assert (e_tnew === e.e_tnew) else begin
                    errors++;
                    $error("[TB] FAIL %s e_tnew: got %0d want %0d", tag, e_tnew, e.e_tnew);
                end
            end
            if (e.chk_m) begin
                checks++;
                assert (m_tnew === e.m_tnew) else begin
                    errors++;
                    $error("[TB] FAIL %s m_tnew: got %0d want %0d", tag, m_tnew, e.m_tnew);
                end
            end
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic checkCount(input string tag, input logic [31:0] want);
        checks++;
        assert (stall_cnt === want) else begin
            errors++;
            $error("[TB] FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, want);
        end
    endtask
`endif

    task automatic runStep(input string tag, input instr_t d, input exp_t e);
        applyStimulus(d, e);
        #1;
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input string tag);
        for (int i = 0; i < 3; i++) begin
            runStep(tag, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        end
    endtask

    instr_t lw1, beq11, addu3, beq30, addu211, jal, jr31, addu0, beq00, self7, ori5, lw5, sw5;

    initial begin
        lw1     = mk(1, 5'd2, 5'd1, 1, 0, T_CAL, 0, 1, 5'd1, T_LOAD);
        beq11   = mk(1, 5'd1, 5'd1, 1, 1, 0, 0, 0, 5'd0, 0);
        addu3   = mk(1, 5'd1, 5'd2, 1, 1, T_CAL, T_CAL, 1, 5'd3, T_CAL);
        beq30   = mk(1, 5'd3, 5'd0, 1, 1, 0, 0, 0, 5'd0, 0);
        addu211 = mk(1, 5'd1, 5'd1, 1, 1, T_CAL, T_CAL, 1, 5'd2, T_CAL);
        jal     = mk(1, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd31, T_LINK);
        jr31    = mk(1, 5'd31, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0);
        addu0   = mk(1, 5'd1, 5'd2, 1, 1, T_CAL, T_CAL, 1, 5'd0, T_CAL);
        beq00   = mk(1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 5'd0, 0);
        self7   = mk(1, 5'd7, 5'd7, 1, 1, T_CAL, T_CAL, 1, 5'd7, T_CAL);
        ori5    = mk(1, 5'd1, 5'd5, 1, 0, T_CAL, 0, 1, 5'd5, T_CAL);
        lw5     = mk(1, 5'd2, 5'd5, 1, 0, T_CAL, 0, 1, 5'd5, T_LOAD);
        sw5     = mk(1, 5'd2, 5'd5, 1, 1, T_CAL, 2'd2, 0, 5'd0, 0);

        reset = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, FWD_RF, FWD_RF, 1, 0, 1, 0));
`ifdef HAZARD_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_state");
`ifdef HAZARD_PERF_CNT_EN
        checkCount("reset_cnt", 32'd0);
`endif

        // lw $1 -> beq $1,$1: two stall cycles, then forward from W
        runStep("lw_beq_lw",    lw1,   ex(0, FWD_RF, FWD_RF, 1, 0, 1, 0));
        runStep("lw_beq_st1",   beq11, ex(1, FWD_RF, FWD_RF, 1, 2, 1, 0));
        runStep("lw_beq_st2",   beq11, ex(1, FWD_RF, FWD_RF, 0, 0, 1, 1));
        runStep("lw_beq_fwdw",  beq11, ex(0, FWD_W, FWD_W, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        checkCount("lw_beq_cnt", 32'd2);
`endif
        flush("flush1");

        // addu $3 -> beq $3,$0: one stall, then forward from M
        runStep("addu_beq_a",   addu3, ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("addu_beq_st",  beq30, ex(1, FWD_RF, FWD_RF, 1, 1, 0, 0));
        runStep("addu_beq_fwd", beq30, ex(0, FWD_M, FWD_RF, 0, 0, 1, 0));
        flush("flush2");

        // lw $1 -> addu $2,$1,$1: one stall, then resolved later (select RF)
        runStep("lw_addu_lw",   lw1,     ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("lw_addu_st",   addu211, ex(1, FWD_RF, FWD_RF, 1, 2, 0, 0));
        runStep("lw_addu_go",   addu211, ex(0, FWD_RF, FWD_RF, 0, 0, 1, 1));
        runStep("lw_addu_ine",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, FWD_RF, FWD_RF, 1, 1, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        checkCount("lw_addu_cnt", 32'd4);
`endif
        flush("flush3");

        // jal -> jr $31 forwards from E; $0 writes never tracked; no self-hazard
        runStep("jal",          jal,   ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("jr_fwde",      jr31,  ex(0, FWD_E, FWD_RF, 1, 0, 0, 0));
        flush("flush4");
        runStep("addu0",        addu0, ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("beq0",         beq00, ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("self7",        self7, ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        flush("flush5");

        // ori $5 in M, lw $5 in E, sw rt=$5: youngest (E, tnew 2) wins, no stall
        runStep("ori5",         ori5,  ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        runStep("lw5",          lw5,   ex(0, FWD_RF, FWD_RF, 1, 1, 0, 0));
        runStep("sw5_youngest", sw5,   ex(0, FWD_RF, FWD_RF, 1, 2, 1, 0));
        flush("flush6");

        // reset asserted in the middle of a lw-beq stall
        runStep("rst_lw",       lw1,   ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        applyStimulus(beq11, ex(1, FWD_RF, FWD_RF, 1, 2, 0, 0));
        #1;
        checkOutput("rst_stalled");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        checkCount("rst_cnt", 32'd0);
`endif
        runStep("rst_after",    beq11, ex(0, FWD_RF, FWD_RF, 1, 0, 1, 0));

`ifdef HAZARD_PERF_CNT_EN
        // clear wins over a concurrent stall increment
        runStep("clr_lw",       lw1,   ex(0, FWD_RF, FWD_RF, 0, 0, 0, 0));
        cnt_clr = 1'b1;
        runStep("clr_st1",      beq11, ex(1, FWD_RF, FWD_RF, 1, 2, 0, 0));
        cnt_clr = 1'b0;
        checkCount("clr_prio", 32'd0);
        runStep("clr_st2",      beq11, ex(1, FWD_RF, FWD_RF, 0, 0, 1, 1));
        checkCount("clr_count", 32'd1);
`endif

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer-side hazard controller for the 5-stage pipeline (F/D/E/M/W). It sits beside the D stage.
- Each D-stage instruction that writes a register hands in its destination register and its Tnew at E entry. The block tracks these in-flight writers through E, M and W.
- It compares each in-flight writer against the current D instruction's source registers and their Tuse values.
- Outputs: the D-stage stall, and the D-stage forwarding selects for rs and rt.

Parameters:
- REG_W, 5, register index width.
- T_W, 2, width of the Tnew and Tuse fields.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all tracking entries.
- id_valid  in  1  D stage holds a real instruction (0 = bubble).
- id_rs  in  REG_W  D-stage rs index.
- id_rt  in  REG_W  D-stage rt index.
- id_rs_re  in  1  D instruction reads rs.
- id_rt_re  in  1  D instruction reads rt.
- id_tuse_rs  in  T_W  cycles until rs is needed (0 = in D, e.g. beq/jr; 1 = in E; 2 = in M).
- id_tuse_rt  in  T_W  same, for rt.
- id_we  in  1  D instruction writes the register file.
- id_wreg  in  REG_W  D instruction destination (rd / rt / 31).
- id_tnew  in  T_W  Tnew at E entry: load 2, cal_r/cal_i 1, jal/jalr 0.
- stall  out  1  freeze PC and the F/D register; the E register loads a bubble.
- fwd_rs_sel  out  2  D-stage rs source: 00 RF, 01 E, 10 M, 11 W.
- fwd_rt_sel  out  2  same, for rt.
- e_tnew  out  T_W  Tnew of the E entry, for debug.
- m_tnew  out  T_W  Tnew of the M entry, for debug.

Behaviour:
- State: three entries, E, M and W, each holding {valid, wreg, tnew}.
- Reset (synchronous, active-high): all entries valid=0, wreg=0, tnew=0. Consequently stall=0, fwd selects=00, e_tnew=m_tnew=0 in the cycle after reset.
- Per clock, when reset=0:
  - W <= M, with W.tnew forced to 0.
  - M <= E, with tnew decremented, saturating at 0.
  - E loads from D when (!stall && id_valid && id_we && id_wreg!=0). Otherwise E.valid=0.
  - A stall therefore always inserts exactly one bubble into E.
- Match: an entry matches a source when entry.valid && entry.wreg==src && src!=0 && the read-enable for that source is set.
- Priority: the youngest match wins (E, then M, then W). Older matches are ignored.
- Stall (combinational from state plus D inputs): stall=1 if id_valid and, for either source, the winning match has tnew > that source's tuse. No match means no stall for that source.
- Forwarding, per source:
  - If the winning match has tnew==0, the select is that stage's code.
  - Otherwise the select is 00. A tnew>0 match that is not stalled is resolved by later-stage forwarding, which is outside this block.
- Register $0 never matches and is never tracked.
- Simultaneous events: the D instruction may read and write the same register. Its own write is not yet in E, so there is no self-hazard.
- Reset mid-stall: stall deasserts in the cycle after reset. In-flight entries are discarded.
- Latency: stall and the selects are same-cycle combinational; the tracking state updates one cycle later.
- Required stall length: stall cycles = max(0, tnew_at_E − tuse). Consecutive stalls occur only while the blocking writer advances from E toward W.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), counting cycles with stall=1.
  - Reset value 0; wraps from 0xFFFFFFFF to 0.
  - Adds input cnt_clr (1 bit), which synchronously zeroes the counter and takes priority over the increment.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package or define file: stage-select codes (FWD_RF=2'b00, FWD_E=2'b01, FWD_M=2'b10, FWD_W=2'b11) and the Tnew/Tuse encodings (T_LOAD=2, T_CAL=1, T_LINK=0).
- One sub-module, hazard_src_check, instantiated once for rs and once for rt:
  - Inputs: the entry state, the source index, its read-enable and its tuse.
  - Outputs: that source's stall request and fwd_sel.

Test Plan:
- lw $1 then beq $1,$1 (tuse 0) -> stall=1 for 2 cycles (E tnew 2, then M tnew 1). Third cycle: stall=0, fwd_rs_sel=11 (W).
- addu $3 then beq $3,$0 -> 1 stall cycle. Next cycle: stall=0, fwd_rs_sel=10 (M).
- lw $1 then addu $2,$1,$1 (tuse 1) -> 1 stall cycle. Next cycle: stall=0 with fwd selects 00, since M tnew 1 <= tuse 1.
- jal then jr $31 -> stall=0, fwd_rs_sel=01 (E). addu $0 followed by beq $0 -> no stall, fwd=00.
- ori $5 in M (tnew 0) and lw $5 in E (tnew 2), then sw with rt=$5 (tuse 2) -> no stall, fwd_rt_sel=00 (youngest entry E wins, tnew 2 <= tuse 2).
- Reset asserted during a lw-beq stall -> next cycle stall=0 and all entries invalid. With HAZARD_PERF_CNT_EN defined, stall_cnt=0 after reset and counts 2 over the first scenario.
